usb_frame_arbiter: RTL and testbench

- Shares the single USB output stream (data_o/valid_o/frame_o) between NB_SRC ble_packet_analyzer instances, e.g. one per channel group.
- Grants the stream one whole frame at a time with round-robin fairness. Frames are never interleaved.
- Watchdogs guard against a granted source that never starts its frame and against a runaway frame.
- Sits between the analyzers and the USB bridge. Outputs are registered.

---
 rtl/usb_arb_pkg.sv | 30 +++
 rtl/rr_picker.sv | 24 ++
 rtl/usb_frame_arbiter.sv | 165 ++++++++++++++++
 tb/tb_usb_frame_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_arb_pkg.sv
// Shared types and helpers for the USB frame arbiter and later multi-source blocks.
// Defines the arbiter state encoding and the round-robin "next requester" search.
package usb_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        STREAM,
        DRAIN,
        GAP
    } arb_state_t;

    localparam int MAX_SRC   = 8;
    localparam int SRC_IDX_W = 3;

    // First set bit of req strictly after ptr, wrapping at n-1; returns ptr when req is empty.
    function automatic int rr_next(input logic [MAX_SRC-1:0] req, input int ptr, input int n);
        int res;
        int idx;
        res = ptr;
        for (int k = MAX_SRC; k >= 1; k--) begin
            idx = (ptr + k) % n;
            if (k <= n && req[idx[SRC_IDX_W-1:0]]) begin
                res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: picks the first requester after ptr_i.
// found_o is set whenever any request is pending.
module rr_picker
    import usb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [MAX_SRC-1:0] req_ext;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req_i;
        idx_o            = IW'(rr_next(req_ext, int'(ptr_i), N));
        found_o          = |req_i;
    end

endmodule

// File: rtl/usb_frame_arbiter.sv
// Shares one USB byte stream between NB_SRC frame sources, one whole frame per grant,
// round-robin order, with a start-of-frame watchdog and a maximum frame length.
module usb_frame_arbiter
    import usb_arb_pkg::*;
#(
    parameter int NB_SRC        = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_FRAME_LEN = 64,
    parameter int START_TIMEOUT = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_SRC-1:0]                src_req_i,
    input  logic [NB_SRC-1:0][DATA_WIDTH-1:0] src_data_i,
    input  logic [NB_SRC-1:0]                src_valid_i,
    input  logic [NB_SRC-1:0]                src_frame_i,
    output logic [NB_SRC-1:0]                src_gnt_o,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             valid_o,
    output logic                             frame_o,
    output logic                             busy_o,
    output logic                             timeout_o,
    output logic                             overflow_o
);

    localparam int IDX_W  = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam int CNT_W  = $clog2(MAX_FRAME_LEN + 1);
    localparam int WAIT_W = $clog2(START_TIMEOUT + 1);

    arb_state_t              state_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        sel_q;
    logic [WAIT_W-1:0]       wait_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NB_SRC-1:0]       gnt_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    valid_q;
    logic                    frame_q;
    logic                    busy_q;
    logic                    timeout_q;
    logic                    overflow_q;

    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_found;
    logic                    sel_req;
    logic                    sel_valid;
    logic                    sel_frame;
    logic [DATA_WIDTH-1:0]   sel_data;

    rr_picker #(
        .N  (NB_SRC),
        .IW (IDX_W)
    ) u_picker (
        .req_i   (src_req_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Only the granted source is ever looked at; everything else on the inputs is ignored.
    assign sel_req   = src_req_i[sel_q];
    assign sel_valid = src_valid_i[sel_q];
    assign sel_frame = src_frame_i[sel_q];
    assign sel_data  = src_data_i[sel_q];

    // Handshake: a source may drive frame/valid/data only while its src_gnt_o bit is set;
    // it keeps src_req_i high until its frame ends, dropping it early withdraws the request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(NB_SRC - 1);
            sel_q      <= '0;
            wait_q     <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q   <= NB_SRC'(1) << pick_idx;
                        sel_q   <= pick_idx;
                        ptr_q   <= pick_idx;
                        wait_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (sel_frame) begin
                        data_q  <= sel_data;
                        valid_q <= sel_valid;
                        frame_q <= 1'b1;
                        cnt_q   <= sel_valid ? CNT_W'(1) : '0;
                        state_q <= STREAM;
                    end else if (!sel_req) begin
                        gnt_q   <= '0;
                        state_q <= GAP;
                    end else if (wait_q == WAIT_W'(START_TIMEOUT - 1)) begin
                        gnt_q     <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= GAP;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                STREAM: begin
                    if (!sel_frame) begin
                        data_q  <= '0;
                        valid_q <= 1'b0;
                        frame_q <= 1'b0;
                        gnt_q   <= '0;
                        state_q <= GAP;
                    end else if (sel_valid && cnt_q == CNT_W'(MAX_FRAME_LEN)) begin
                        // Truncate: grant stays so the source can finish its frame unheard.
                        data_q     <= '0;
                        valid_q    <= 1'b0;
                        frame_q    <= 1'b0;
                        overflow_q <= 1'b1;
                        state_q    <= DRAIN;
                    end else begin
                        data_q  <= sel_data;
                        valid_q <= sel_valid;
                        frame_q <= 1'b1;
                        if (sel_valid) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!sel_frame) begin
                        gnt_q   <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign src_gnt_o  = gnt_q;
    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign frame_o    = frame_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_usb_frame_arbiter.sv
// Directed bench for usb_frame_arbiter: each task drives one scenario and checks the
// packed output vector against hand-computed values every cycle.
module tb_usb_frame_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       req = '0;
    logic [3:0][7:0]  sdata = '0;
    logic [3:0]       valid = '0;
    logic [3:0]       frame = '0;

    logic [3:0]       gnt;
    logic [7:0]       data_o;
    logic             valid_o;
    logic             frame_o;
    logic             busy_o;
    logic             timeout_o;
    logic             overflow_o;

    int total = 0;
    int bad   = 0;

    wire [16:0] obs = {gnt, valid_o, frame_o, data_o, busy_o, timeout_o, overflow_o};

    usb_frame_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_req_i   (req),
        .src_data_i  (sdata),
        .src_valid_i (valid),
        .src_frame_i (frame),
        .src_gnt_o   (gnt),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_o     (frame_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [16:0] ev(input logic [3:0] g, input logic v, input logic f,
                                       input logic [7:0] d, input logic b, input logic t,
                                       input logic o);
        return {g, v, f, d, b, t, o};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req   = '0;
        valid = '0;
        frame = '0;
        sdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [16:0] e;
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        e = ev(4'b0000, 0, 0, 8'h00, 0, 0, 0);
        if (obs !== e) begin $display("FAIL reset_async: got %h want %h", obs, e); bad++; end
        total++;
        tick();
        if (obs !== e) begin $display("FAIL reset_held: got %h want %h", obs, e); bad++; end
        total++;
        rst = 1'b0;
        tick();
        if (obs !== e) begin $display("FAIL idle_no_req: got %h want %h", obs, e); bad++; end
        total++;
    endtask

    task automatic test_single;
        logic [16:0] e;
        logic [7:0]  bytes [3];
        bytes = '{8'hA1, 8'hA2, 8'hA3};
        req = 4'b0001;
        tick();
        e = ev(4'b0001, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL sf_grant: got %h want %h", obs, e); bad++; end
        total++;
        frame[0] = 1'b1;
        valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sdata[0] = bytes[k];
            tick();
            e = ev(4'b0001, 1, 1, bytes[k], 1, 0, 0);
            if (obs !== e) begin $display("FAIL sf_byte%0d: got %h want %h", k, obs, e); bad++; end
            total++;
        end
        idle_inputs();
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL sf_end: got %h want %h", obs, e); bad++; end
        total++;
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 0, 0, 0);
        if (obs !== e) begin $display("FAIL sf_gap_done: got %h want %h", obs, e); bad++; end
        total++;
    endtask

    task automatic test_fairness;
        logic [16:0] e;
        logic [3:0]  g;
        logic [7:0]  d;
        int          order [5];
        int          s;
        order = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        tick();
        for (int f = 0; f < 5; f++) begin
            s = order[f];
            g = 4'(1 << s);
            e = ev(g, 0, 0, 8'h00, 1, 0, 0);
            if (obs !== e) begin $display("FAIL fair_gnt%0d: got %h want %h", f, obs, e); bad++; end
            total++;
            // Non-granted sources drive noise that must never reach the output.
            frame = 4'b1111;
            valid = 4'b1111;
            sdata = {4{8'hEE}};
            for (int k = 1; k <= 2; k++) begin
                d = 8'(s * 16 + k);
                sdata[s] = d;
                tick();
                e = ev(g, 1, 1, d, 1, 0, 0);
                if (obs !== e) begin $display("FAIL fair_f%0d_b%0d: got %h want %h", f, k, obs, e); bad++; end
                total++;
            end
            frame = '0;
            valid = '0;
            sdata = '0;
            tick();
            e = ev(4'b0000, 0, 0, 8'h00, 1, 0, 0);
            if (obs !== e) begin $display("FAIL fair_end%0d: got %h want %h", f, obs, e); bad++; end
            total++;
            if (f == 4) req = '0;
            tick();
            e = ev(4'b0000, 0, 0, 8'h00, 0, 0, 0);
            if (obs !== e) begin $display("FAIL fair_idle%0d: got %h want %h", f, obs, e); bad++; end
            total++;
            if (f < 4) tick();
        end
    endtask

    task automatic test_timeout;
        logic [16:0] e;
        do_reset();
        req = 4'b1100;
        tick();
        e = ev(4'b0100, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL to_gnt: got %h want %h", obs, e); bad++; end
        total++;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (obs !== e) begin $display("FAIL to_wait%0d: got %h want %h", i, obs, e); bad++; end
            total++;
        end
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 1, 1, 0);
        if (obs !== e) begin $display("FAIL to_pulse: got %h want %h", obs, e); bad++; end
        total++;
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 0, 0, 0);
        if (obs !== e) begin $display("FAIL to_gap_done: got %h want %h", obs, e); bad++; end
        total++;
        tick();
        e = ev(4'b1000, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL to_next_gnt: got %h want %h", obs, e); bad++; end
        total++;
        req = '0;
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL to_withdraw: got %h want %h", obs, e); bad++; end
        total++;
        tick();
    endtask

    task automatic test_overflow;
        logic [16:0] e;
        int          fwd;
        fwd = 0;
        do_reset();
        req = 4'b0010;
        tick();
        e = ev(4'b0010, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL ov_gnt: got %h want %h", obs, e); bad++; end
        total++;
        frame[1] = 1'b1;
        valid[1] = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            sdata[1] = 8'(k);
            tick();
            if (valid_o) fwd++;
            if (k <= 64)      e = ev(4'b0010, 1, 1, 8'(k), 1, 0, 0);
            else if (k == 65) e = ev(4'b0010, 0, 0, 8'h00, 1, 0, 1);
            else              e = ev(4'b0010, 0, 0, 8'h00, 1, 0, 0);
            if (obs !== e) begin $display("FAIL ov_byte%0d: got %h want %h", k, obs, e); bad++; end
            total++;
        end
        if (fwd !== 64) begin $display("FAIL ov_count: got %0d want 64", fwd); bad++; end
        total++;
        idle_inputs();
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL ov_release: got %h want %h", obs, e); bad++; end
        total++;
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 0, 0, 0);
        if (obs !== e) begin $display("FAIL ov_idle: got %h want %h", obs, e); bad++; end
        total++;
    endtask

    task automatic test_reset_mid;
        logic [16:0] e;
        req = 4'b0100;
        tick();
        e = ev(4'b0100, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL rm_gnt: got %h want %h", obs, e); bad++; end
        total++;
        frame[2] = 1'b1;
        valid[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sdata[2] = 8'(8'h30 + k);
            tick();
            e = ev(4'b0100, 1, 1, 8'(8'h30 + k), 1, 0, 0);
            if (obs !== e) begin $display("FAIL rm_byte%0d: got %h want %h", k, obs, e); bad++; end
            total++;
        end
        #3 rst = 1'b1;
        #1;
        e = ev(4'b0000, 0, 0, 8'h00, 0, 0, 0);
        if (obs !== e) begin $display("FAIL rm_async_drop: got %h want %h", obs, e); bad++; end
        total++;
        tick();
        idle_inputs();
        rst = 1'b0;
        req = 4'b0011;
        tick();
        e = ev(4'b0001, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL rm_first_gnt: got %h want %h", obs, e); bad++; end
        total++;
        req = '0;
        tick();
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 0, 0, 0);
        if (obs !== e) begin $display("FAIL rm_idle: got %h want %h", obs, e); bad++; end
        total++;
    endtask

    task automatic test_withdraw;
        logic [16:0] e;
        req = 4'b0100;
        tick();
        e = ev(4'b0100, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL wd_gnt: got %h want %h", obs, e); bad++; end
        total++;
        tick();
        if (obs !== e) begin $display("FAIL wd_hold: got %h want %h", obs, e); bad++; end
        total++;
        req = '0;
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 1, 0, 0);
        if (obs !== e) begin $display("FAIL wd_revoke: got %h want %h", obs, e); bad++; end
        total++;
        tick();
        e = ev(4'b0000, 0, 0, 8'h00, 0, 0, 0);
        if (obs !== e) begin $display("FAIL wd_idle: got %h want %h", obs, e); bad++; end
        total++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
